// File: rtl/sram_test_pkg.sv
// rtl/sram_test_pkg.sv - Shared types and constants for the SRAM test sequencer
package sram_test_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_RD,
    ST_CHK,
    ST_DONE
  } state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Taps 16,14,13,11 of a right-shifting Fibonacci LFSR land on bits 0,2,3,5.
  localparam logic [15:0] LFSR_TAPS = 16'h002D;
  localparam int          ERR_W     = 16;

endpackage

// File: rtl/sram_pattern_gen.sv
// rtl/sram_pattern_gen.sv - Test data source: address count, or 16-bit LFSR when SRAM_TEST_LFSR_EN is defined
// restart rewinds the sequence to its first word, advance steps it once per address.
module sram_pattern_gen
  import sram_test_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              restart,
  input  logic              advance,
  input  logic              phase,
  output logic [DATA_W-1:0] pattern
);

  logic [DATA_W-1:0] base;

`ifdef SRAM_TEST_LFSR_EN
  logic [15:0] lfsr;

  // Reset clears to zero; every run begins with a restart that loads the seed.
  always_ff @(posedge clock) begin
    if (reset) begin
      lfsr <= '0;
    end else if (restart) begin
      lfsr <= LFSR_SEED;
    end else if (advance) begin
      lfsr <= {^(lfsr & LFSR_TAPS), lfsr[15:1]};
    end
  end

  if (DATA_W == 16) begin : g_eq
    assign base = lfsr;
  end else if (DATA_W > 16) begin : g_wide
    assign base = {{(DATA_W-16){1'b0}}, lfsr};
  end else begin : g_narrow
    assign base = lfsr[DATA_W-1:0];
  end
`else
  logic [DATA_W-1:0] count;

  // Tracks the low DATA_W bits of the sequencer address.
  always_ff @(posedge clock) begin
    if (reset || restart) begin
      count <= '0;
    end else if (advance) begin
      count <= count + 1'b1;
    end
  end

  assign base = count;
`endif

  assign pattern = base ^ {DATA_W{phase}};

endmodule

// File: rtl/sram_test_seq.sv
// rtl/sram_test_seq.sv - Two-pass SRAM write/read-back tester; phase 1 writes the inverse of phase 0
// Optional SRAM_TEST_LFSR_EN switches the data pattern to an LFSR sequence.
module sram_test_seq
  import sram_test_pkg::*;
#(
  parameter int                ADDR_W    = 20,
  parameter int                DATA_W    = 16,
  parameter logic [ADDR_W-1:0] LAST_ADDR = 20'hFFFFF,
  parameter int                RD_LAT    = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic              r_request,
  input  logic              w_ready,
  output logic [DATA_W-1:0] data_in,
  output logic [ADDR_W-1:0] in_addr,
  output logic [ADDR_W-1:0] out_addr,
  input  logic [DATA_W-1:0] data_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic [ADDR_W-1:0] first_err_addr
);

  localparam int                CNT_W   = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [CNT_W-1:0]  RD_LOAD = CNT_W'(RD_LAT - 1);

  state_t            state, state_n;
  logic              phase;
  logic [ADDR_W-1:0] addr;
  logic [CNT_W-1:0]  rd_cnt;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic [DATA_W-1:0] pattern;

  logic clear_run, addr_step, gen_restart, gen_advance, do_cmp, load_cnt, phase_set;
  logic at_last, mismatch;

  assign at_last  = (addr == LAST_ADDR);
  assign mismatch = do_cmp && (data_out != pattern);

  always_comb begin
    state_n     = state;
    clear_run   = 1'b0;
    addr_step   = 1'b0;
    gen_restart = 1'b0;
    gen_advance = 1'b0;
    do_cmp      = 1'b0;
    load_cnt    = 1'b0;
    phase_set   = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_n     = ST_WR;
          clear_run   = 1'b1;
          gen_restart = 1'b1;
        end
      end
      ST_WR: begin
        if (w_ready) begin
          addr_step = 1'b1;
          if (at_last) begin
            state_n     = ST_RD;
            gen_restart = 1'b1;
            load_cnt    = 1'b1;
          end else begin
            gen_advance = 1'b1;
          end
        end
      end
      ST_RD: begin
        if (rd_cnt == '0) state_n = ST_CHK;
      end
      ST_CHK: begin
        do_cmp    = 1'b1;
        addr_step = 1'b1;
        if (at_last) begin
          gen_restart = 1'b1;
          if (phase) begin
            state_n = ST_DONE;
          end else begin
            state_n   = ST_WR;
            phase_set = 1'b1;
          end
        end else begin
          state_n     = ST_RD;
          gen_advance = 1'b1;
          load_cnt    = 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= ST_IDLE;
      phase          <= 1'b0;
      addr           <= '0;
      rd_cnt         <= '0;
      wr_addr_q      <= '0;
      wr_data_q      <= '0;
      err_count      <= '0;
      first_err_addr <= '0;
    end else begin
      state <= state_n;
      if (clear_run)      phase <= 1'b0;
      else if (phase_set) phase <= 1'b1;
      if (clear_run)      addr <= '0;
      else if (addr_step) addr <= at_last ? '0 : addr + 1'b1;
      if (load_cnt)                           rd_cnt <= RD_LOAD;
      else if (state == ST_RD && rd_cnt != '0) rd_cnt <= rd_cnt - 1'b1;
      // Last WR-cycle values stay on the write port so stray writes are harmless.
      if (state == ST_WR) begin
        wr_addr_q <= addr;
        wr_data_q <= pattern;
      end
      if (clear_run) begin
        err_count      <= '0;
        first_err_addr <= '0;
      end else if (mismatch) begin
        if (err_count == '0) first_err_addr <= addr;
        if (err_count != '1) err_count <= err_count + 1'b1;
      end
    end
  end

  sram_pattern_gen #(.DATA_W(DATA_W)) u_pattern_gen (
    .clock   (clock),
    .reset   (reset),
    .restart (gen_restart),
    .advance (gen_advance),
    .phase   (phase),
    .pattern (pattern)
  );

  assign in_addr   = (state == ST_WR) ? addr : wr_addr_q;
  assign data_in   = (state == ST_WR) ? pattern : wr_data_q;
  assign out_addr  = addr;
  assign r_request = (state == ST_RD) || (state == ST_CHK);
  assign busy      = (state == ST_WR) || (state == ST_RD) || (state == ST_CHK);
  assign done      = (state == ST_DONE);
  assign pass      = done && (err_count == '0);

endmodule
